fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Producer side of the instruction/control interface: holds PC, instruction register, cycle bit and carry flag, and drives `inst`, `cycle` and `carry` into the combinational control decoder.
- Consumes the decoder's sequencing outputs (multi-cycle, jump, link-jump, write-carry) and steps the CPU through fetch, execute cycle 0 and the optional execute cycle 1.
- Talks to instruction memory over a req/valid handshake and honours a data-memory stall in the second execute cycle.

Parameters:
- ADDR_W, 16, PC / instruction-address width.
- RESET_PC, 0, PC value loaded on reset (truncated to ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_valid  in  1  fetch data valid.
- imem_rdata  in  8  fetched instruction byte.
- inst  out  8  instruction register to decoder.
- cycle  out  1  execute-cycle index to decoder.
- carry  out  1  carry flag to decoder.
- exec_valid  out  1  high in EXEC0/EXEC1; decoder outputs are meaningful only then.
- mc  in  1  decoder: instruction needs a second cycle (sampled in EXEC0).
- j  in  1  decoder: take jump at retire.
- lj  in  1  decoder: link-and-jump at retire.
- jump_target  in  ADDR_W  jump destination from the register file.
- wc  in  1  write carry this cycle.
- alu_cout  in  1  ALU carry out.
- carry_clr  in  1  clear carry this cycle.
- dmem_stall  in  1  hold EXEC1.
- retire  out  1  one-cycle pulse on the instruction's last execute cycle.
- link_we  out  1  one-cycle pulse; write link_addr.
- link_addr  out  ADDR_W  pc+1 of the retiring instruction.
- pc  out  ADDR_W  current PC.

Behaviour:
- Reset (asynchronous, any state, including mid-fetch or mid-stall):
  - state = FETCH, pc = RESET_PC, inst = 8'h00, carry = 0.
  - cycle, exec_valid, retire, link_we, imem_req all 0 while rst_n is low.
  - imem_req rises in the first clk after release.
- FETCH:
  - imem_req = 1, cycle = 0, exec_valid = 0.
  - Waits indefinitely for imem_valid; on imem_valid, inst <= imem_rdata and next state = EXEC0.
  - imem_valid outside FETCH is ignored.
- EXEC0:
  - cycle = 0, exec_valid = 1.
  - If mc = 1, next state = EXEC1.
  - If mc = 0, the instruction retires this cycle.
- EXEC1:
  - cycle = 1, exec_valid = 1.
  - If dmem_stall = 1, hold EXEC1; no retire, no carry update, inst and pc unchanged.
  - If dmem_stall = 0, the instruction retires this cycle.
- Retire cycle:
  - retire = 1.
  - pc update priority: lj > j > increment.
    - lj: pc <= jump_target, link_we = 1, link_addr = pc+1.
    - j: pc <= jump_target.
    - otherwise: pc <= pc+1.
  - pc+1 wraps modulo 2^ADDR_W, including for link_addr.
  - Next state = FETCH.
  - Minimum latency is 2 clocks per single-cycle instruction with 0-wait memory, 3 per multi-cycle instruction.
- Carry:
  - Updated only when exec_valid = 1 and not stalled.
  - carry_clr takes priority over wc: carry <= 0.
  - Otherwise, if wc = 1, carry <= alu_cout.
  - The new carry is visible to the decoder from the next clock.
- j, lj, wc and carry_clr are ignored in FETCH and during a stalled EXEC1.
- link_addr holds its last value when link_we = 0.
- mc is ignored outside EXEC0.

Optional Feature:
- Macro: FETCH_SEQUENCER_RETIRE_COUNT_EN.
- Defined:
  - Adds output retired_count (32 bits), reset to 0, incremented on every retire pulse, wrapping at 2^32.
  - Adds output stall_count (16 bits), incremented on every stalled EXEC1 cycle, saturating at 16'hFFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, memory returns 8'h00 with 0 waits:
  - imem_addr sequences 0,1,2.
  - retire pulses every 2nd clock.
  - inst = 8'h00 and carry = 0 throughout.
- Fetch wait: imem_valid withheld 3 clocks at pc=5:
  - imem_req stays high and state remains FETCH.
  - inst loads on the 4th clock.
  - exec_valid is 0 during the waits.
- Multi-cycle with jump: inst 8'hE0, mc=1 in EXEC0, j=1 in EXEC1, jump_target=16'h1234, dmem_stall high 2 clocks:
  - cycle=1 for 3 clocks.
  - single retire pulse.
  - next imem_addr = 16'h1234.
- Link-jump at pc=16'hFFFF with lj=1, jump_target=16'h0040:
  - link_we pulse with link_addr = 16'h0000.
  - pc = 16'h0040.
- Carry: wc=1/alu_cout=1 in EXEC0, then carry_clr=1 and wc=1/alu_cout=1 together in the next EXEC0:
  - carry = 1, then 0.
  - wc asserted during FETCH leaves carry unchanged.
- Async reset asserted mid-stall in EXEC1:
  - outputs clear immediately, without a clock edge.
  - after release, fetch restarts at RESET_PC.
  - with FETCH_SEQUENCER_RETIRE_COUNT_EN defined, retired_count = 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
`timescale 1ns/1ps
// fetch_sequencer: producer side of the instruction/control interface.
// Holds pc, the instruction register, the execute-cycle bit and the carry
// flag. It steps each instruction through FETCH -> EXEC0 [-> EXEC1] and
// retires it on its last execute cycle.
//
// Optional build macro FETCH_SEQUENCER_RETIRE_COUNT_EN adds the retired_count
// and stall_count outputs. The default build leaves both out.
//
// Handshake: imem_req is high for every FETCH cycle after reset release and
// stays high until the byte arrives. A byte is accepted on a rising edge where
// imem_req && imem_valid. imem_valid is ignored while imem_req is low, and
// imem_req never drops while it waits for imem_valid.
module fetch_sequencer #(
  parameter int          ADDR_W   = 16,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [7:0]        imem_rdata,
  output logic [7:0]        inst,
  output logic              cycle,
  output logic              carry,
  output logic              exec_valid,
  input  logic              mc,
  input  logic              j,
  input  logic              lj,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              wc,
  input  logic              alu_cout,
  input  logic              carry_clr,
  input  logic              dmem_stall,
  output logic              retire,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
`ifdef FETCH_SEQUENCER_RETIRE_COUNT_EN
  output logic [31:0]       retired_count,
  output logic [15:0]       stall_count,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] PC_INIT = RESET_PC[ADDR_W-1:0];

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC0 = 2'd1,
    S_EXEC1 = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              run;        // low for the reset period and for the first clock after release
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] link_q;
  logic              stalled;
  logic              carry_en;

  // pc+1 wraps naturally at 2^ADDR_W
  assign pc_inc     = pc + ADDR_W'(1);
  assign imem_addr  = pc;
  assign imem_req   = (state == S_FETCH) && run;
  assign exec_valid = (state != S_FETCH);
  assign cycle      = (state == S_EXEC1);
  assign stalled    = (state == S_EXEC1) && dmem_stall;
  assign carry_en   = exec_valid && !stalled;
  assign link_we    = retire && lj;
  assign link_addr  = link_we ? pc_inc : link_q;
  assign dbg_state  = state;

  // State register. run holds off the first request until one clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  // Next state and the retire strobe
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        if (run && imem_valid) state_nxt = S_EXEC0;
      end
      S_EXEC0: begin
        if (mc) begin
          state_nxt = S_EXEC1;
        end else begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC1: begin
        if (!dmem_stall) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Instruction register: loads only on an accepted fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst <= 8'h00;
    end else if (imem_req && imem_valid) begin
      inst <= imem_rdata;
    end
  end

  // PC update at retire. lj takes priority over j, and j over the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_INIT;
    end else if (retire) begin
      if (lj || j) pc <= jump_target;
      else         pc <= pc_inc;
    end
  end

  // Link address register, so link_addr holds between link writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_q <= '0;
    end else if (link_we) begin
      link_q <= pc_inc;
    end
  end

  // Carry flag. A clear beats a write, and both are ignored in FETCH and stalled EXEC1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
    end else if (carry_en) begin
      if (carry_clr) carry <= 1'b0;
      else if (wc)   carry <= alu_cout;
    end
  end

`ifdef FETCH_SEQUENCER_RETIRE_COUNT_EN
  // Retire counter that wraps, and a stall counter that saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count <= 32'd0;
      stall_count   <= 16'd0;
    end else begin
      if (retire) retired_count <= retired_count + 32'd1;
      if (stalled && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
// tb_fetch_sequencer: self-checking bench for fetch_sequencer.
// A table of instruction records runs first, then a few random records and a
// hand-written async reset asserted during a stall. Each record carries its
// expected next pc, link address and carry. Expected pc and link values go
// into queues when the retire cycle is driven. The monitor pops them when the
// DUT retires or writes the link.
module tb_fetch_sequencer;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_valid;
  logic [7:0]        imem_rdata;
  logic [7:0]        inst;
  logic              cycle;
  logic              carry;
  logic              exec_valid;
  logic              mc, j, lj, wc, alu_cout, carry_clr, dmem_stall;
  logic [ADDR_W-1:0] jump_target;
  logic              retire;
  logic              link_we;
  logic [ADDR_W-1:0] link_addr;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        dbg_state;
`ifdef FETCH_SEQUENCER_RETIRE_COUNT_EN
  logic [31:0]       retired_count;
  logic [15:0]       stall_count;
`endif

  fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(64'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .inst(inst), .cycle(cycle), .carry(carry), .exec_valid(exec_valid),
    .mc(mc), .j(j), .lj(lj), .jump_target(jump_target),
    .wc(wc), .alu_cout(alu_cout), .carry_clr(carry_clr), .dmem_stall(dmem_stall),
    .retire(retire), .link_we(link_we), .link_addr(link_addr),
`ifdef FETCH_SEQUENCER_RETIRE_COUNT_EN
    .retired_count(retired_count), .stall_count(stall_count),
`endif
    .pc(pc), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] link_q[$];
  logic [ADDR_W-1:0] pend_pc;
  bit                pend = 1'b0;
  logic [ADDR_W-1:0] cur_pc;
  logic              cur_carry;
  int                exp_stalls;
  int                exp_retires;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: the retire cycle pops the expected next pc, and the next negedge compares it
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        chk("next_pc", pc, pend_pc);
      end
      if (retire) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_retire: got retire=1 expected 0 at pc %0h", pc);
        end else begin
          pend_pc = exp_q.pop_front();
          pend    = 1'b1;
        end
      end
      if (link_we) begin
        if (link_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_link_we: got link_we=1 expected 0 at pc %0h", pc);
        end else begin
          chk("link_addr", link_addr, link_q.pop_front());
        end
      end
    end
  end

  // ---------------- records ----------------
  typedef struct {
    int          waits;
    logic [7:0]  inst;
    bit          mc;
    int          stalls;
    bit          j;
    bit          lj;
    logic [15:0] tgt;
    bit          wc;
    bit          cout;
    bit          clr;
    logic [15:0] exp_pc;
    logic [15:0] exp_link;
    bit          exp_carry;
  } rec_t;

  function automatic rec_t mk(int waits, logic [7:0] ins, bit m, int stalls, bit jj, bit ljj,
                              logic [15:0] tgt, bit w, bit co, bit cl,
                              logic [15:0] epc, logic [15:0] elink, bit ec);
    rec_t r;
    r.waits = waits; r.inst = ins; r.mc = m; r.stalls = stalls;
    r.j = jj; r.lj = ljj; r.tgt = tgt; r.wc = w; r.cout = co; r.clr = cl;
    r.exp_pc = epc; r.exp_link = elink; r.exp_carry = ec;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Control inputs that must have no effect in the cycle they are driven
  task automatic drive_noise();
    mc          = 1'($urandom_range(0, 1));
    j           = 1'b1;
    lj          = 1'b1;
    jump_target = 16'($urandom_range(0, 65535));
    wc          = 1'b1;
    alu_cout    = ~cur_carry;
    carry_clr   = cur_carry;
    dmem_stall  = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_retire(input rec_t r);
    j           = r.j;
    lj          = r.lj;
    jump_target = r.tgt;
    wc          = r.wc;
    alu_cout    = r.cout;
    carry_clr   = r.clr;
    exp_q.push_back(r.exp_pc);
    if (r.lj) link_q.push_back(r.exp_link);
  endtask

  task automatic chk_fetch();
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, cur_pc);
    chk("fetch_exec_valid", exec_valid, 0);
    chk("fetch_cycle", cycle, 0);
    chk("fetch_retire", retire, 0);
    chk("fetch_link_we", link_we, 0);
    chk("fetch_carry", carry, cur_carry);
    chk("fetch_state", dbg_state, 0);
  endtask

  // Entry: just after a rising edge, with the DUT in FETCH and imem_req high
  task automatic do_inst(input rec_t r);
    for (int w = 0; w < r.waits; w++) begin
      imem_valid = 1'b0;
      imem_rdata = 8'($urandom_range(0, 255));
      drive_noise();
      @(negedge clk); chk_fetch();
      @(posedge clk); #1;
    end
    imem_valid = 1'b1;
    imem_rdata = r.inst;
    drive_noise();
    @(negedge clk); chk_fetch();
    @(posedge clk); #1;
    // EXEC0: stray imem_valid with different data must not reload inst
    imem_valid = 1'($urandom_range(0, 1));
    imem_rdata = ~r.inst;
    dmem_stall = 1'($urandom_range(0, 1));
    if (r.mc) begin
      mc = 1'b1; j = 1'b1; lj = 1'b1;
      jump_target = 16'($urandom_range(0, 65535));
      wc = 1'b0; carry_clr = 1'b0; alu_cout = 1'b1;
    end else begin
      mc = 1'b0;
      drive_retire(r);
    end
    @(negedge clk);
    chk("e0_inst", inst, r.inst);
    chk("e0_exec_valid", exec_valid, 1);
    chk("e0_cycle", cycle, 0);
    chk("e0_req", imem_req, 0);
    chk("e0_carry", carry, cur_carry);
    chk("e0_retire", retire, !r.mc);
    @(posedge clk); #1;
    if (r.mc) begin
      for (int s = 0; s < r.stalls; s++) begin
        drive_noise();
        dmem_stall = 1'b1;
        @(negedge clk);
        chk("stall_cycle", cycle, 1);
        chk("stall_exec_valid", exec_valid, 1);
        chk("stall_retire", retire, 0);
        chk("stall_carry", carry, cur_carry);
        chk("stall_inst", inst, r.inst);
        chk("stall_pc", pc, cur_pc);
        @(posedge clk); #1;
      end
      mc = 1'($urandom_range(0, 1));
      dmem_stall = 1'b0;
      drive_retire(r);
      @(negedge clk);
      chk("e1_cycle", cycle, 1);
      chk("e1_retire", retire, 1);
      chk("e1_carry", carry, cur_carry);
      chk("e1_state", dbg_state, 2);
      @(posedge clk); #1;
      exp_stalls += r.stalls;
    end
    exp_retires++;
    cur_carry = r.exp_carry;
    cur_pc    = r.exp_pc;
  endtask

  // ---------------- test ----------------
  rec_t tbl[13];

  initial begin
    tbl[0]  = mk(0, 8'h00, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0001, 16'h0000, 0);
    tbl[1]  = mk(0, 8'h00, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0002, 16'h0000, 0);
    tbl[2]  = mk(0, 8'h00, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0003, 16'h0000, 0);
    tbl[3]  = mk(0, 8'hA5, 0, 0, 1, 0, 16'h0005, 0, 0, 0, 16'h0005, 16'h0000, 0);
    tbl[4]  = mk(3, 8'h3C, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0006, 16'h0000, 0);
    tbl[5]  = mk(0, 8'hE0, 1, 2, 1, 0, 16'h1234, 0, 0, 0, 16'h1234, 16'h0000, 0);
    tbl[6]  = mk(0, 8'h11, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h1235, 16'h0000, 1);
    tbl[7]  = mk(0, 8'h22, 0, 0, 0, 0, 16'h0000, 1, 1, 1, 16'h1236, 16'h0000, 0);
    tbl[8]  = mk(0, 8'h33, 1, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h1237, 16'h0000, 1);
    tbl[9]  = mk(0, 8'h44, 0, 0, 1, 0, 16'hFFFF, 0, 0, 0, 16'hFFFF, 16'h0000, 1);
    tbl[10] = mk(1, 8'h55, 0, 0, 0, 1, 16'h0040, 0, 0, 0, 16'h0040, 16'h0000, 1);
    tbl[11] = mk(0, 8'h66, 1, 1, 1, 1, 16'h0100, 0, 0, 0, 16'h0100, 16'h0041, 1);
    tbl[12] = mk(2, 8'h77, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 16'h0101, 16'h0000, 0);

    rst_n = 1'b0; imem_valid = 1'b0; imem_rdata = 8'h00;
    mc = 0; j = 0; lj = 0; jump_target = '0; wc = 0; alu_cout = 0; carry_clr = 0; dmem_stall = 0;
    cur_pc = 16'h0000; cur_carry = 1'b0; exp_stalls = 0; exp_retires = 0;

    // Reset values while rst_n is held low
    repeat (3) @(posedge clk);
    imem_valid = 1'b1;
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_exec_valid", exec_valid, 0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_inst", inst, 8'h00);
    chk("rst_carry", carry, 0);
    chk("rst_retire", retire, 0);
    rst_n = 1'b1;
    #1 chk("release_req_before_clk", imem_req, 0);
    @(posedge clk); #1;
    chk("release_req_after_clk", imem_req, 1);

    for (int i = 0; i < 13; i++) do_inst(tbl[i]);

    for (int k = 0; k < 6; k++) begin
      rec_t r;
      r.waits  = $urandom_range(0, 2);
      r.inst   = 8'($urandom_range(0, 255));
      r.mc     = 1'($urandom_range(0, 1));
      r.stalls = $urandom_range(0, 2);
      r.j      = 1'($urandom_range(0, 1));
      r.lj     = 1'($urandom_range(0, 1));
      r.tgt    = 16'($urandom_range(0, 65535));
      r.wc     = 1'($urandom_range(0, 1));
      r.cout   = 1'($urandom_range(0, 1));
      r.clr    = 1'($urandom_range(0, 1));
      r.exp_pc    = (r.j || r.lj) ? r.tgt : cur_pc + 16'd1;
      r.exp_link  = cur_pc + 16'd1;
      r.exp_carry = r.clr ? 1'b0 : (r.wc ? r.cout : cur_carry);
      do_inst(r);
    end

`ifdef FETCH_SEQUENCER_RETIRE_COUNT_EN
    @(negedge clk);
    chk("retired_count", retired_count, exp_retires);
    chk("stall_count", stall_count, exp_stalls);
    @(posedge clk); #1;
`endif

    // Async reset during a stalled EXEC1
    imem_valid = 1'b1; imem_rdata = 8'h99; drive_noise();
    @(posedge clk); #1;
    imem_valid = 1'b0; mc = 1'b1; wc = 1'b1; alu_cout = 1'b1; carry_clr = 1'b0; j = 0; lj = 0;
    @(posedge clk); #1;
    dmem_stall = 1'b1; wc = 1'b0; carry_clr = 1'b0;
    @(negedge clk);
    chk("pre_rst_cycle", cycle, 1);
    chk("pre_rst_carry", carry, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_exec_valid", exec_valid, 0);
    chk("mid_rst_cycle", cycle, 0);
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_retire", retire, 0);
    chk("mid_rst_pc", pc, 16'h0000);
    chk("mid_rst_inst", inst, 8'h00);
    chk("mid_rst_carry", carry, 0);
`ifdef FETCH_SEQUENCER_RETIRE_COUNT_EN
    chk("mid_rst_retired_count", retired_count, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    dmem_stall = 1'b0;
    rst_n = 1'b1;
    cur_pc = 16'h0000; cur_carry = 1'b0; exp_retires = 0;
    @(posedge clk); #1;
    do_inst(mk(0, 8'h00, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0001, 16'h0000, 0));
    @(negedge clk);
`ifdef FETCH_SEQUENCER_RETIRE_COUNT_EN
    chk("post_rst_retired_count", retired_count, exp_retires);
`endif
    @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("link_q_drained", link_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
